// File: rtl/comparator_arbiter.sv
// comparator_arbiter: one registered unsigned magnitude comparator shared among N_REQ
// requesters. A round-robin arbiter picks the requester; the block latches that
// requester's operands and returns a one-hot result with a one-cycle ack.
// Optional macro COMPARE_STATS_EN adds saturating 8-bit result counters.
module comparator_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] A_bus,
  input  logic [N_REQ*WIDTH-1:0] B_bus,
  output logic [N_REQ-1:0]       ack,
  output logic                   res_valid,
  output logic [ID_W-1:0]        res_id,
  output logic                   ALB,
  output logic                   AEB,
  output logic                   ASB,
  output logic                   busy
`ifdef COMPARE_STATS_EN
  ,
  output logic [7:0]             cnt_gt,
  output logic [7:0]             cnt_eq,
  output logic [7:0]             cnt_lt
`endif
);

  typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              alb_q, alb_d, aeb_q, aeb_d, asb_q, asb_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              res_valid_q, res_valid_d;
`ifdef COMPARE_STATS_EN
  logic [7:0]        cnt_gt_q, cnt_gt_d, cnt_eq_q, cnt_eq_d, cnt_lt_q, cnt_lt_d;
`endif

  logic [WIDTH-1:0]  a_arr [N_REQ];
  logic [WIDTH-1:0]  b_arr [N_REQ];
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand_id;

  // Split the flat operand buses into per-requester slices.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = A_bus[i*WIDTH +: WIDTH];
      b_arr[i] = B_bus[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: first set req bit searching upward from last_grant+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand_id    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand_id = ID_W'((32'(last_grant_q) + i) % N_REQ);
      if (!pick_found && req[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Next-state, operand capture, compare and response generation.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    res_id_d     = res_id_q;
    alb_d        = alb_q;
    aeb_d        = aeb_q;
    asb_d        = asb_q;
    ack_d        = '0;
    res_valid_d  = 1'b0;
`ifdef COMPARE_STATS_EN
    cnt_gt_d     = cnt_gt_q;
    cnt_eq_d     = cnt_eq_q;
    cnt_lt_d     = cnt_lt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          a_d      = a_arr[pick_id];
          b_d      = b_arr[pick_id];
          gnt_id_d = pick_id;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        // Result, ack and valid all register here so they appear together in RESP.
        alb_d          = (a_q > b_q);
        aeb_d          = (a_q == b_q);
        asb_d          = (a_q < b_q);
        res_id_d       = gnt_id_q;
        ack_d[gnt_id_q] = 1'b1;
        res_valid_d    = 1'b1;
        state_d        = StResp;
      end
      StResp: begin
        last_grant_d = gnt_id_q;
        state_d      = StIdle;
`ifdef COMPARE_STATS_EN
        if (alb_q && (cnt_gt_q != 8'hFF)) cnt_gt_d = cnt_gt_q + 8'd1;
        if (aeb_q && (cnt_eq_q != 8'hFF)) cnt_eq_d = cnt_eq_q + 8'd1;
        if (asb_q && (cnt_lt_q != 8'hFF)) cnt_lt_d = cnt_lt_q + 8'd1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; synchronous reset aborts any compare in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      gnt_id_q     <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      res_id_q     <= '0;
      alb_q        <= 1'b0;
      aeb_q        <= 1'b0;
      asb_q        <= 1'b0;
      ack_q        <= '0;
      res_valid_q  <= 1'b0;
`ifdef COMPARE_STATS_EN
      cnt_gt_q     <= '0;
      cnt_eq_q     <= '0;
      cnt_lt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      res_id_q     <= res_id_d;
      alb_q        <= alb_d;
      aeb_q        <= aeb_d;
      asb_q        <= asb_d;
      ack_q        <= ack_d;
      res_valid_q  <= res_valid_d;
`ifdef COMPARE_STATS_EN
      cnt_gt_q     <= cnt_gt_d;
      cnt_eq_q     <= cnt_eq_d;
      cnt_lt_q     <= cnt_lt_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign ALB       = alb_q;
  assign AEB       = aeb_q;
  assign ASB       = asb_q;
  assign busy      = (state_q != StIdle);
`ifdef COMPARE_STATS_EN
  assign cnt_gt    = cnt_gt_q;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_lt    = cnt_lt_q;
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed self-checking bench for comparator_arbiter (N_REQ=4, WIDTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_comparator_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  ack;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        alb, aeb, asb, busy;
`ifdef COMPARE_STATS_EN
  logic [7:0]  cnt_gt, cnt_eq, cnt_lt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comparator_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .A_bus     (a_bus),
    .B_bus     (b_bus),
    .ack       (ack),
    .res_valid (res_valid),
    .res_id    (res_id),
    .ALB       (alb),
    .AEB       (aeb),
    .ASB       (asb),
    .busy      (busy)
`ifdef COMPARE_STATS_EN
    ,
    .cnt_gt    (cnt_gt),
    .cnt_eq    (cnt_eq),
    .cnt_lt    (cnt_lt)
`endif
  );

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    a_bus[i*4 +: 4] = a;
    b_bus[i*4 +: 4] = b;
  endtask

  // Wait (bounded) for a nonzero ack; lat is negedges waited, -1 on timeout.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d expected 0", res_id); end
    checks++; if ({alb, aeb, asb} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {alb, aeb, asb}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    set_op(0, 4'd9, 4'd3);
    req = 4'b0001;
    @(negedge clk);
    checks++; if ({busy, ack} !== 5'b1_0000) begin failures++; $display("FAIL single_cmp: got busy/ack %b expected 1_0000", {busy, ack}); end
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack: got %b expected 0001", ack); end
    checks++; if ({res_valid, busy} !== 2'b11) begin failures++; $display("FAIL single_valid_busy: got %b expected 11", {res_valid, busy}); end
    checks++; if ({alb, aeb, asb} !== 3'b100) begin failures++; $display("FAIL single_flags: got %b expected 100", {alb, aeb, asb}); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d expected 0", res_id); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if ({busy, res_valid, ack} !== 6'b00_0000) begin failures++; $display("FAIL single_after: got busy/valid/ack %b expected 000000", {busy, res_valid, ack}); end
    checks++; if ({alb, aeb, asb} !== 3'b100) begin failures++; $display("FAIL single_hold: got %b expected 100", {alb, aeb, asb}); end
    @(negedge clk);
  endtask

  task automatic test_eq_lt_gt();
    logic [3:0] va, vb;
    logic [2:0] exp;
    int lat;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       begin va = 4'd5;  vb = 4'd5;  exp = 3'b010; end
        1:       begin va = 4'd0;  vb = 4'd15; exp = 3'b001; end
        default: begin va = 4'd15; vb = 4'd0;  exp = 3'b100; end
      endcase
      set_op(2, va, vb);
      req = 4'b0100;
      wait_ack(lat);
      req = 4'b0000;
      checks++; if (lat !== 2) begin failures++; $display("FAIL elg_latency[%0d]: got %0d expected 2", v, lat); end
      checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL elg_ack[%0d]: got %b expected 0100", v, ack); end
      checks++; if ({alb, aeb, asb} !== exp) begin failures++; $display("FAIL elg_flags[%0d]: got %b expected %b", v, {alb, aeb, asb}, exp); end
      checks++; if (res_id !== 2'd2) begin failures++; $display("FAIL elg_id[%0d]: got %0d expected 2", v, res_id); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int         ack_k [6];
    logic [3:0] ack_v [6];
    logic [1:0] ack_i [6];
    int         n;
    logic [3:0] pend;
    logic [3:0] exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd2);
    n = 0;
    pend = 4'b0000;
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req  = req | pend;
      pend = 4'b0000;
      if (ack != 4'b0000) begin
        if (n < 6) begin
          ack_k[n] = k;
          ack_v[n] = ack;
          ack_i[n] = res_id;
        end
        n++;
        req  = req & ~ack;
        pend = ack;
      end
    end
    req = 4'b0000;
    checks++; if (n < 6) begin failures++; $display("FAIL rr_count: got %0d acks expected at least 6", n); end
    for (int j = 0; j < 6 && j < n; j++) begin
      exp_v = 4'b0001 << (j % 4);
      checks++; if (ack_v[j] !== exp_v) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", j, ack_v[j], exp_v); end
      checks++; if (ack_k[j] !== 2 + 3 * j) begin failures++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", j, ack_k[j], 2 + 3 * j); end
      checks++; if (ack_i[j] !== 2'(j % 4)) begin failures++; $display("FAIL rr_id[%0d]: got %0d expected %0d", j, ack_i[j], j % 4); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_operand_capture();
    int lat;
    set_op(1, 4'd7, 4'd2);
    req = 4'b0010;
    @(negedge clk);
    set_op(1, 4'd0, 4'd9);
    wait_ack(lat);
    req = 4'b0000;
    checks++; if (lat !== 1) begin failures++; $display("FAIL cap_latency: got %0d expected 1", lat); end
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL cap_ack: got %b expected 0010", ack); end
    checks++; if ({alb, aeb, asb} !== 3'b100) begin failures++; $display("FAIL cap_flags: got %b expected 100", {alb, aeb, asb}); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    set_op(3, 4'd1, 4'd8);
    req = 4'b1000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ack, res_valid, busy} !== 6'b0000_00) begin failures++; $display("FAIL mid_ctrl: got ack/valid/busy %b expected 000000", {ack, res_valid, busy}); end
    checks++; if ({alb, aeb, asb, res_id} !== 5'b000_00) begin failures++; $display("FAIL mid_result: got flags/id %b expected 00000", {alb, aeb, asb, res_id}); end
    rst = 1'b0;
    set_op(0, 4'd3, 4'd3);
    req = 4'b1001;
    wait_ack(lat);
    req = 4'b1000;
    checks++; if (lat !== 2) begin failures++; $display("FAIL mid_latency: got %0d expected 2", lat); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL mid_first: got %b expected 0001", ack); end
    checks++; if ({alb, aeb, asb} !== 3'b010) begin failures++; $display("FAIL mid_flags: got %b expected 010", {alb, aeb, asb}); end
    wait_ack(lat);
    req = 4'b0000;
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL mid_second: got %b expected 1000", ack); end
    checks++; if ({alb, aeb, asb} !== 3'b001) begin failures++; $display("FAIL mid_second_flags: got %b expected 001", {alb, aeb, asb}); end
    repeat (2) @(negedge clk);
  endtask

`ifdef COMPARE_STATS_EN
  task automatic test_stats();
    int lat;
    int timeouts;
    do_reset();
    timeouts = 0;
    set_op(0, 4'd12, 4'd4);
    for (int n = 0; n < 300; n++) begin
      req = 4'b0001;
      wait_ack(lat);
      req = 4'b0000;
      if (lat < 0) timeouts++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL stats_timeouts: got %0d expected 0", timeouts); end
    checks++; if (cnt_gt !== 8'd255) begin failures++; $display("FAIL stats_gt: got %0d expected 255", cnt_gt); end
    checks++; if ({cnt_eq, cnt_lt} !== 16'd0) begin failures++; $display("FAIL stats_eq_lt: got %0d/%0d expected 0/0", cnt_eq, cnt_lt); end
    do_reset();
    checks++; if ({cnt_gt, cnt_eq, cnt_lt} !== 24'd0) begin failures++; $display("FAIL stats_clear: got %0d/%0d/%0d expected 0/0/0", cnt_gt, cnt_eq, cnt_lt); end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    a_bus = '0;
    b_bus = '0;
    test_reset();
    test_single();
    test_eq_lt_gt();
    test_round_robin();
    test_operand_capture();
    test_reset_mid();
`ifdef COMPARE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_arbiter.md
Name: comparator_arbiter

Overview:
- Shares one registered WIDTH-bit magnitude comparator among N_REQ requesters.
- Each requester presents an operand pair and holds a request; the block picks one requester by round-robin, latches its operands and compares them.
- It returns a registered one-hot result (greater / equal / less) plus a one-cycle ack to the granted requester.
- Used wherever several blocks need occasional compares and one comparator instance is enough.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits, unsigned
- ID_W, $clog2(N_REQ), width of res_id (derived, do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  request per requester; level, held until the matching ack
- A_bus  input  N_REQ*WIDTH  operand A; requester i drives bits [i*WIDTH +: WIDTH]
- B_bus  input  N_REQ*WIDTH  operand B; same slicing as A_bus
- ack  output  N_REQ  one-hot, one-cycle pulse to the served requester
- res_valid  output  1  one-cycle pulse; result outputs updated this cycle
- res_id  output  ID_W  index of the served requester; held until next result
- ALB  output  1  A > B; held until next result
- AEB  output  1  A == B; held until next result
- ASB  output  1  A < B; held until next result
- busy  output  1  high in CMP and RESP

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and last_grant = N_REQ-1, so req[0] has top priority first.
- FSM states:
  - IDLE: if req != 0, pick the first set bit searching upward from last_grant+1, modulo N_REQ. Latch A_q, B_q and gnt_id from that slice, then go to CMP. Otherwise stay in IDLE.
  - CMP: compute ALB/AEB/ASB from A_q and B_q into the result registers, set res_id = gnt_id, go to RESP. Exactly one flag is high.
  - RESP: res_valid = 1 and ack[gnt_id] = 1 for this cycle only. last_grant <= gnt_id, go to IDLE.
- Latency: if req is first seen in IDLE at cycle t, ack and res_valid are high in cycle t+2.
- Throughput: at most one compare per 3 cycles.
- Operand capture: operands are captured at the IDLE->CMP edge only. Changes on A_bus/B_bus after capture do not affect that result.
- Request release: the requester must drop req in the cycle after ack. A req still high when the FSM is back in IDLE counts as a new request; round-robin order still applies, so it is not served twice in a row while others are pending.
- Ignored requests: requests arriving or dropping during CMP/RESP are not sampled. A req dropped before its grant is not served.
- Comparison: unsigned, full WIDTH. Boundaries 0 vs 2^WIDTH-1 must flag correctly.
- Before the first result: ALB = AEB = ASB = 0 and res_id = 0.
- Reset mid-operation: takes priority over all state. No ack or res_valid is issued for the aborted compare. Result registers clear to 0 and last_grant returns to N_REQ-1.
- No combinational path from req or A_bus/B_bus to any output.

Optional Feature:
- Macro: COMPARE_STATS_EN
- When defined, adds three outputs: cnt_gt, cnt_eq, cnt_lt, each 8-bit.
  - In the RESP cycle, the counter matching the produced flag increments by 1.
  - Counters saturate at 255.
  - Counters clear to 0 on rst.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single request: after reset, req=0001, A0=9, B0=3 -> ack=0001 and res_valid at cycle t+2; ALB=1, AEB=0, ASB=0, res_id=0; busy high for 2 cycles.
- Equal and less: req[2] with A=5, B=5 -> AEB=1, res_id=2. Then A=0, B=15 -> ASB=1. Then A=15, B=0 -> ALB=1.
- Round-robin: req=1111 held, each requester drops req the cycle after its ack and re-asserts the next cycle -> ack order 0,1,2,3,0,1, one ack every 3 cycles, no requester served twice while others wait.
- Operand capture: req[1] with A=7, B=2; change A1 to 0 during CMP -> result still ALB=1.
- Reset mid-operation: assert rst during CMP with req[3] pending -> no ack; all outputs 0 the next cycle. With req=1001 after release, req[0] is granted first.
- Stats (COMPARE_STATS_EN): 300 compares with A>B -> cnt_gt=255 (saturated), cnt_eq=0, cnt_lt=0; rst clears all three to 0.
